// File: rtl/snake_pkg.sv
// Shared snake-game constants and types.
//   MAX_SEGMENTS : segment slots carried on the packed position buses
//   BLK_SIZE     : segment sprite edge in pixels
//   COORD_W      : screen coordinate width
//   OFF_W        : in-sprite offset width (log2 of BLK_SIZE)
//   IDX_W        : segment index width
//   sched_state_t: line scheduler FSM states
package snake_pkg;

    localparam int MAX_SEGMENTS = 23;
    localparam int BLK_SIZE     = 32;
    localparam int COORD_W      = 11;
    localparam int OFF_W        = 5;
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_READY = 2'd2
    } sched_state_t;

endpackage

// File: rtl/seg_x_match.sv
// Horizontal match for one hit-list entry.
// Ports:
//   valid : entry holds a listed segment
//   sx    : segment left edge
//   x     : current pixel column
//   match : valid and sx <= x < sx + BLK_SIZE
//   offx  : x - sx, low OFF_W bits
module seg_x_match #(
    parameter int BLK_SIZE = snake_pkg::BLK_SIZE
) (
    input  logic                          valid,
    input  logic [snake_pkg::COORD_W-1:0] sx,
    input  logic [snake_pkg::COORD_W-1:0] x,
    output logic                          match,
    output logic [snake_pkg::OFF_W-1:0]   offx
);
    import snake_pkg::*;

    // One extra bit so sx + BLK_SIZE cannot wrap near the right screen edge.
    localparam logic [COORD_W:0] BLK_EXT = BLK_SIZE[COORD_W:0];

    logic [COORD_W:0] sx_e;
    logic [COORD_W:0] x_e;

    assign sx_e  = {1'b0, sx};
    assign x_e   = {1'b0, x};
    assign match = valid && (sx_e <= x_e) && (x_e < sx_e + BLK_EXT);
    assign offx  = OFF_W'(x - sx);

endmodule

// File: rtl/seg_line_sched.sv
// Per-scanline segment scheduler. During horizontal blanking it walks the
// snake segments once, building a short list of those crossing the next row;
// during the visible line it resolves the pixel against that list.
// Ports:
//   clk, rst             : clock, async active-high reset
//   line_start, next_y   : start a scan for row next_y
//   snakepos_x/_y, length: packed segment positions (segment 0 = head)
//   curr_x, active       : current pixel column / visible flag
//   seg_hit..seg_offy    : registered pixel result (1-cycle latency)
//   busy, list_cnt, overflow : scan status
//
// state    | meaning
// ST_IDLE  | after reset, no list built yet
// ST_SCAN  | testing one segment per cycle against the latched row
// ST_READY | list valid, resolving pixels against it
module seg_line_sched #(
    parameter int MAX_SEGMENTS = snake_pkg::MAX_SEGMENTS,
    parameter int LIST_DEPTH   = 8,
    parameter int BLK_SIZE     = snake_pkg::BLK_SIZE
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       line_start,
    input  logic [snake_pkg::COORD_W-1:0]              next_y,
    input  logic [snake_pkg::COORD_W*MAX_SEGMENTS-1:0] snakepos_x,
    input  logic [snake_pkg::COORD_W*MAX_SEGMENTS-1:0] snakepos_y,
    input  logic [5:0]                                 length,
    input  logic [snake_pkg::COORD_W-1:0]              curr_x,
    input  logic                                       active,
    output logic                                       seg_hit,
    output logic [snake_pkg::IDX_W-1:0]                seg_idx,
    output logic [snake_pkg::OFF_W-1:0]                seg_offx,
    output logic [snake_pkg::OFF_W-1:0]                seg_offy,
    output logic                                       busy,
    output logic [3:0]                                 list_cnt,
    output logic                                       overflow
);
    import snake_pkg::*;

    localparam logic [COORD_W:0] BLK_EXT  = BLK_SIZE[COORD_W:0];
    localparam logic [5:0]       MAX_LEN  = 6'(MAX_SEGMENTS);
    localparam logic [3:0]       LIST_MAX = 4'(LIST_DEPTH);

    sched_state_t       state;
    logic [COORD_W-1:0] line_y;
    logic [5:0]         eff_len;
    logic [IDX_W-1:0]   scan_idx;

    // Hit-list payload; validity is implied by position < list_cnt.
    logic [IDX_W-1:0]   ent_idx  [LIST_DEPTH];
    logic [COORD_W-1:0] ent_sx   [LIST_DEPTH];
    logic [OFF_W-1:0]   ent_offy [LIST_DEPTH];

    logic [COORD_W-1:0] cur_sx;
    logic [COORD_W-1:0] cur_sy;
    logic               hit_y;
    logic               last_seg;
    logic               scan_test;
    logic               list_wr;

    assign busy = (state == ST_SCAN);

    always_comb begin
        cur_sx = '0;
        cur_sy = '0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_sx = snakepos_x[COORD_W*i +: COORD_W];
                cur_sy = snakepos_y[COORD_W*i +: COORD_W];
            end
        end
    end

    assign hit_y     = ({1'b0, cur_sy} <= {1'b0, line_y}) &&
                       ({1'b0, line_y} < {1'b0, cur_sy} + BLK_EXT);
    assign last_seg  = ({1'b0, scan_idx} == eff_len - 6'd1);
    assign scan_test = (state == ST_SCAN) && !line_start && (eff_len != 6'd0);
    assign list_wr   = scan_test && hit_y && (list_cnt < LIST_MAX);

    // Horizontal matching and priority pick (lowest list position wins).
    logic [LIST_DEPTH-1:0] match;
    logic [OFF_W-1:0]      match_offx [LIST_DEPTH];

    for (genvar k = 0; k < LIST_DEPTH; k++) begin : g_match
        seg_x_match #(.BLK_SIZE(BLK_SIZE)) u_match (
            .valid (4'(k) < list_cnt),
            .sx    (ent_sx[k]),
            .x     (curr_x),
            .match (match[k]),
            .offx  (match_offx[k])
        );
    end

    logic             pick_hit;
    logic [IDX_W-1:0] pick_idx;
    logic [OFF_W-1:0] pick_offx;
    logic [OFF_W-1:0] pick_offy;
    logic             out_en;

    always_comb begin
        pick_hit  = 1'b0;
        pick_idx  = '0;
        pick_offx = '0;
        pick_offy = '0;
        for (int k = LIST_DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                pick_hit  = 1'b1;
                pick_idx  = ent_idx[k];
                pick_offx = match_offx[k];
                pick_offy = ent_offy[k];
            end
        end
    end

    // A line_start in READY must not leak a hit into the first SCAN cycle.
    assign out_en = (state == ST_READY) && !line_start && active && pick_hit;

    always_ff @(posedge clk) begin
        for (int k = 0; k < LIST_DEPTH; k++) begin
            if (list_wr && (list_cnt == 4'(k))) begin
                ent_idx[k]  <= scan_idx;
                ent_sx[k]   <= cur_sx;
                ent_offy[k] <= OFF_W'(line_y - cur_sy);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            line_y   <= '0;
            eff_len  <= '0;
            scan_idx <= '0;
            list_cnt <= '0;
            overflow <= 1'b0;
            seg_hit  <= 1'b0;
            seg_idx  <= '0;
            seg_offx <= '0;
            seg_offy <= '0;
        end else begin
            seg_hit  <= out_en;
            seg_idx  <= out_en ? pick_idx  : '0;
            seg_offx <= out_en ? pick_offx : '0;
            seg_offy <= out_en ? pick_offy : '0;

            if (line_start) begin
                line_y   <= next_y;
                eff_len  <= (length > MAX_LEN) ? MAX_LEN : length;
                list_cnt <= '0;
                overflow <= 1'b0;
                scan_idx <= '0;
                state    <= ST_SCAN;
            end else begin
                case (state)
                    ST_SCAN: begin
                        if (eff_len == 6'd0) begin
                            state <= ST_READY;
                        end else begin
                            if (hit_y) begin
                                if (list_cnt < LIST_MAX) list_cnt <= list_cnt + 4'd1;
                                else                     overflow <= 1'b1;
                            end
                            if (last_seg) state <= ST_READY;
                            else          scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                    ST_READY: state <= ST_READY;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_line_sched.sv
module tb_seg_line_sched;

    localparam int NSEG = 23;
    localparam int LD   = 8;
    localparam int BLK  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_start;
    logic [10:0]   next_y;
    logic [252:0]  snakepos_x;
    logic [252:0]  snakepos_y;
    logic [5:0]    length;
    logic [10:0]   curr_x;
    logic          active;
    logic          seg_hit;
    logic [4:0]    seg_idx;
    logic [4:0]    seg_offx;
    logic [4:0]    seg_offy;
    logic          busy;
    logic [3:0]    list_cnt;
    logic          overflow;

    seg_line_sched dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .next_y     (next_y),
        .snakepos_x (snakepos_x),
        .snakepos_y (snakepos_y),
        .length     (length),
        .curr_x     (curr_x),
        .active     (active),
        .seg_hit    (seg_hit),
        .seg_idx    (seg_idx),
        .seg_offx   (seg_offx),
        .seg_offy   (seg_offy),
        .busy       (busy),
        .list_cnt   (list_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [4:0] idx;
        logic [4:0] offx;
        logic [4:0] offy;
    } pix_t;

    pix_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int sx_m [NSEG];
    int sy_m [NSEG];
    int len_m;
    int ny_m;
    bit ready_m;
    int m_cnt;
    int m_hits;
    int m_ent [LD];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int eff_len_m();
        return (len_m > NSEG) ? NSEG : len_m;
    endfunction

    function void build_list();
        m_hits = 0;
        m_cnt  = 0;
        for (int i = 0; i < eff_len_m(); i++) begin
            if (sy_m[i] <= ny_m && ny_m < sy_m[i] + BLK) begin
                if (m_cnt < LD) begin
                    m_ent[m_cnt] = i;
                    m_cnt++;
                end
                m_hits++;
            end
        end
    endfunction

    function automatic pix_t model_pix(input int x, input bit act);
        pix_t r;
        r.hit = 1'b0; r.idx = '0; r.offx = '0; r.offy = '0;
        if (ready_m && act) begin
            for (int k = m_cnt - 1; k >= 0; k--) begin
                int s;
                s = m_ent[k];
                if (sx_m[s] <= x && x < sx_m[s] + BLK) begin
                    r.hit  = 1'b1;
                    r.idx  = 5'(s);
                    r.offx = 5'(x - sx_m[s]);
                    r.offy = 5'(ny_m - sy_m[s]);
                end
            end
        end
        return r;
    endfunction

    task automatic load_pos(input int len);
        len_m = len;
        length = 6'(len);
        for (int i = 0; i < NSEG; i++) begin
            snakepos_x[11*i +: 11] = 11'(sx_m[i]);
            snakepos_y[11*i +: 11] = 11'(sy_m[i]);
        end
    endtask

    task automatic clear_pos();
        for (int i = 0; i < NSEG; i++) begin
            sx_m[i] = 1500;
            sy_m[i] = 1500;
        end
    endtask

    task automatic start_line(input string tag, input int ny);
        int cyc;
        int exp_len;
        cyc = 0;
        ny_m = ny;
        next_y = 11'(ny);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        ready_m = 1'b0;
        build_list();
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            tick();
        end
        ready_m = 1'b1;
        exp_len = (eff_len_m() == 0) ? 1 : eff_len_m();
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_len));
        chk({tag, "_list_cnt"}, 32'(list_cnt), 32'(m_cnt));
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_hits > LD));
    endtask

    task automatic pix(input string tag, input int x, input bit act);
        pix_t e;
        pix_t o;
        curr_x = 11'(x);
        active = act;
        e = model_pix(x, act);
        sb.push_back(e);
        tick();
        o = sb.pop_front();
        chk({tag, "_hit"},  32'(seg_hit),  32'(o.hit));
        chk({tag, "_idx"},  32'(seg_idx),  32'(o.idx));
        chk({tag, "_offx"}, 32'(seg_offx), 32'(o.offx));
        chk({tag, "_offy"}, 32'(seg_offy), 32'(o.offy));
        active = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_seg_hit"},  32'(seg_hit),  0);
        chk({tag, "_seg_idx"},  32'(seg_idx),  0);
        chk({tag, "_seg_offx"}, 32'(seg_offx), 0);
        chk({tag, "_seg_offy"}, 32'(seg_offy), 0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_list_cnt"}, 32'(list_cnt), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic load_row10();
        clear_pos();
        for (int i = 0; i < 10; i++) begin
            sx_m[i] = 32 * i;
            sy_m[i] = 300;
        end
        load_pos(10);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        line_start = 1'b0;
        next_y = '0;
        snakepos_x = '0;
        snakepos_y = '0;
        length = '0;
        curr_x = '0;
        active = 1'b0;
        ready_m = 1'b0;
        len_m = 0;
        ny_m = 0;
        clear_pos();
        #1 rst = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Idle: no hit even with active high
        pix("idle", 100, 1'b1);

        // Single head
        clear_pos();
        sx_m[0] = 100; sy_m[0] = 200;
        load_pos(1);
        start_line("head", 215);
        pix("head_x131", 131, 1'b1);
        pix("head_x132", 132, 1'b1);
        pix("head_x100", 100, 1'b1);
        pix("head_x99", 99, 1'b1);
        pix("head_inactive", 131, 1'b0);

        // Overlap priority
        clear_pos();
        sx_m[0] = 64;  sy_m[0] = 64;
        sx_m[1] = 500; sy_m[1] = 500;
        sx_m[2] = 64;  sy_m[2] = 64;
        load_pos(3);
        start_line("overlap", 64);
        pix("overlap_x70", 70, 1'b1);

        // Overflow
        load_row10();
        start_line("ovf", 310);
        pix("ovf_x260", 260, 1'b1);
        pix("ovf_x250", 250, 1'b1);
        pix("ovf_x0", 0, 1'b1);

        // Vertical boundaries
        clear_pos();
        sx_m[0] = 2000; sy_m[0] = 1000;
        load_pos(1);
        start_line("yb_1031", 1031);
        pix("yb_1031_x2031", 2031, 1'b1);
        start_line("yb_1032", 1032);
        pix("yb_1032_x2010", 2010, 1'b1);

        clear_pos();
        sx_m[0] = 2016; sy_m[0] = 2016;
        load_pos(1);
        start_line("edge2016", 2047);
        pix("edge2016_x2047", 2047, 1'b1);

        // Zero length
        clear_pos();
        sx_m[0] = 10; sy_m[0] = 10;
        load_pos(0);
        start_line("len0", 20);
        pix("len0_x20", 20, 1'b1);

        // Length clamp: 40 requested, 23 scanned
        for (int i = 0; i < NSEG; i++) begin
            sx_m[i] = 40 * i;
            sy_m[i] = 0;
        end
        sx_m[22] = 1800;
        load_pos(40);
        start_line("len40", 5);
        pix("len40_x45", 45, 1'b1);

        // Restart mid-scan
        load_row10();
        ny_m = 310;
        next_y = 11'd310;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        ready_m = 1'b0;
        repeat (4) tick();
        chk("rs_precnt", 32'(list_cnt), 4);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("rs_cnt_cleared", 32'(list_cnt), 0);
        chk("rs_busy", 32'(busy), 1);
        build_list();
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            tick();
        end
        ready_m = 1'b1;
        chk("rs_busy_cycles", 32'(cyc), 10);
        chk("rs_list_cnt", 32'(list_cnt), 32'(m_cnt));
        chk("rs_overflow", 32'(overflow), 1);
        pix("rs_x40", 40, 1'b1);

        // Asynchronous reset mid-scan
        next_y = 11'd310;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        ready_m = 1'b0;
        repeat (3) tick();
        chk("rst_pre_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        #3 rst = 1'b0;
        repeat (3) tick();
        chk("rst_after_busy", 32'(busy), 0);
        chk("rst_after_cnt", 32'(list_cnt), 0);
        pix("rst_after_x10", 10, 1'b1);

        // Recovery after reset
        start_line("recover", 310);
        pix("recover_x33", 33, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
